// File: rtl/sw_debounce.sv
// sw_debounce: input conditioning for the board switch bus.
// Each bit is synchronised into clk_i, debounced on its own counter, and
// reported as a clean level, rise/fall pulses and a sticky change flag.
// rst_ni asserts asynchronously; its release is expected to arrive already
// aligned to clk_i from the upstream reset generator.
module sw_debounce #(
  parameter int WIDTH           = 32,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] sw_raw_i,
  input  logic [WIDTH-1:0] clr_i,
  output logic [WIDTH-1:0] sw_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic [WIDTH-1:0] sw_changed_o,
  output logic             changed_any_o
);

  localparam int CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [CntW-1:0]  r_cnt  [WIDTH];
  logic [WIDTH-1:0] r_sw;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic [WIDTH-1:0] r_changed;

  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_mismatch;
  logic [WIDTH-1:0] w_accept;

  // Synchroniser chain; only the last stage is ever looked at downstream.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        r_sync[k] <= '0;
      end
    end else begin
      r_sync[0] <= sw_raw_i;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  assign w_sync     = r_sync[SYNC_STAGES-1];
  assign w_mismatch = w_sync ^ r_sw;

  // A bit is accepted once it has disagreed with the output for the full window.
  always_comb begin
    w_accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_accept[i] = w_mismatch[i] && (r_cnt[i] == CntLast);
    end
  end

  // Per-bit counters restart on any agreement and on acceptance, so they never wrap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!w_mismatch[i] || w_accept[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CntW'(1);
        end
      end
    end
  end

  // Clean level, edge pulses and sticky flags; a transition beats a clear on the same edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sw      <= '0;
      r_rise    <= '0;
      r_fall    <= '0;
      r_changed <= '0;
    end else begin
      r_sw      <= r_sw ^ w_accept;
      r_rise    <= w_accept & w_sync;
      r_fall    <= w_accept & ~w_sync;
      r_changed <= w_accept | (r_changed & ~clr_i);
    end
  end

  assign sw_o          = r_sw;
  assign rise_o        = r_rise;
  assign fall_o        = r_fall;
  assign sw_changed_o  = r_changed;
  assign changed_any_o = |r_changed;

endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: directed scenarios plus a random phase, all compared
// against a history-window reference model of the switch conditioner.
module tb_sw_debounce;

  localparam int W  = 32;
  localparam int SS = 2;
  localparam int DC = 4;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic [W-1:0] sw_raw_i = '0;
  logic [W-1:0] clr_i = '0;
  logic [W-1:0] sw_o;
  logic [W-1:0] rise_o;
  logic [W-1:0] fall_o;
  logic [W-1:0] sw_changed_o;
  logic         changed_any_o;

  int passCount  = 0;
  int failCount  = 0;
  int checkCount = 0;
  int pulseCount;

  // Reference model: raw values since reset, synchronised values seen by the filter.
  logic [W-1:0] rawHist [$];
  logic [W-1:0] sHist   [$];
  logic [W-1:0] mSw, mRise, mFall, mChanged;

  sw_debounce #(
    .WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .sw_raw_i(sw_raw_i), .clr_i(clr_i),
    .sw_o(sw_o), .rise_o(rise_o), .fall_o(fall_o),
    .sw_changed_o(sw_changed_o), .changed_any_o(changed_any_o)
  );

  // Free-running 10 ns clock.
  always #5 clk_i = ~clk_i;

  task automatic modelReset();
    rawHist.delete();
    sHist.delete();
    mSw = '0; mRise = '0; mFall = '0; mChanged = '0;
  endtask

  // One clock edge: the filter sees raw delayed by SS edges; a bit flips when
  // every one of the last DC observed values disagreed with the current output.
  task automatic modelEdge(input logic [W-1:0] raw, input logic [W-1:0] clr);
    logic [W-1:0] sSeen;
    logic [W-1:0] acc;
    if (!rst_ni) return;
    sSeen = (rawHist.size() >= SS) ? rawHist[rawHist.size() - SS] : '0;
    rawHist.push_back(raw);
    if (rawHist.size() > SS) void'(rawHist.pop_front());
    sHist.push_back(sSeen);
    if (sHist.size() > DC) void'(sHist.pop_front());
    acc = '0;
    if (sHist.size() == DC) begin
      acc = '1;
      foreach (sHist[j]) acc &= (sHist[j] ^ mSw);
    end
    mRise    = acc & sSeen;
    mFall    = acc & ~sSeen;
    mSw      = mSw ^ acc;
    mChanged = acc | (mChanged & ~clr);
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checkCount++;
    assert (obs === exp) passCount = passCount + 1;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    check({tag, " sw"},     sw_o,          mSw);
    check({tag, " rise"},   rise_o,        mRise);
    check({tag, " fall"},   fall_o,        mFall);
    check({tag, " flags"},  sw_changed_o,  mChanged);
    check({tag, " any"},    W'(changed_any_o), W'(|mChanged));
  endtask

  // Drive inputs, take one edge, advance the model and sample 1 ns later.
  task automatic applyStimulus(input logic [W-1:0] raw, input logic [W-1:0] clr);
    sw_raw_i = raw;
    clr_i    = clr;
    @(posedge clk_i);
    modelEdge(raw, clr);
    #1;
  endtask

  task automatic resetDut();
    rst_ni = 1'b0;
    modelReset();
    #1;
    checkOutput("reset");
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  // Directed scenarios followed by a random phase.
  initial begin
    logic [W-1:0] rawR;
    logic [W-1:0] bounce [8];
    bounce = '{32'h8, 32'h8, 32'h0, 32'h0, 32'h8, 32'h8, 32'h0, 32'h0};

    // 1: clean press, visible after exactly 6 edges
    sw_raw_i = '0;
    resetDut();
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(32'h1, '0);
      checkOutput("t1");
      if (k == 5) check("t1 early", sw_o, 32'h0);
    end
    check("t1 sw", sw_o, 32'h1);
    check("t1 rise", rise_o, 32'h1);
    check("t1 any", W'(changed_any_o), 32'h1);
    applyStimulus(32'h1, '0);
    checkOutput("t1 post");
    check("t1 rise gone", rise_o, 32'h0);

    // 2: bounce rejection on bit 3
    resetDut();
    pulseCount = 0;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(bounce[k], '0);
      checkOutput("t2 bounce");
      pulseCount += int'(rise_o[3]);
    end
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(32'h8, '0);
      checkOutput("t2 hold");
      pulseCount += int'(rise_o[3]);
      if (k == 5) check("t2 early", W'(sw_o[3]), 32'h0);
      if (k == 6) check("t2 sw", W'(sw_o[3]), 32'h1);
    end
    check("t2 pulses", W'(pulseCount), 32'h1);

    // 3: release with clear on the accepting edge, set wins
    resetDut();
    for (int k = 0; k < 7; k++) applyStimulus(32'h1, '0);
    checkOutput("t3 pressed");
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(32'h0, (k == 6) ? 32'h1 : 32'h0);
      checkOutput("t3 release");
    end
    check("t3 fall", fall_o, 32'h1);
    check("t3 flag kept", sw_changed_o, 32'h1);
    applyStimulus(32'h0, 32'h1);
    checkOutput("t3 clear");
    check("t3 flag cleared", sw_changed_o, 32'h0);
    applyStimulus(32'h0, 32'h0);
    checkOutput("t3 idle");

    // 4: many bits at once
    resetDut();
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(32'hA5A5_0F0F, '0);
      checkOutput("t4");
    end
    check("t4 sw", sw_o, 32'hA5A5_0F0F);
    check("t4 rise", rise_o, 32'hA5A5_0F0F);
    check("t4 fall", fall_o, 32'h0);

    // 5: reset in the middle of a debounce
    resetDut();
    for (int k = 0; k < 3; k++) applyStimulus(32'h80, '0);
    rst_ni = 1'b0;
    modelReset();
    #1;
    checkOutput("t5 async");
    check("t5 sw zero", sw_o, 32'h0);
    applyStimulus(32'h80, '0);
    rst_ni = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(32'h80, '0);
      checkOutput("t5");
      if (k == 5) check("t5 early", sw_o, 32'h0);
    end
    check("t5 sw", sw_o, 32'h80);

    // 6: glitch one cycle short of the window
    resetDut();
    pulseCount = 0;
    for (int k = 0; k < 11; k++) begin
      applyStimulus((k < 3) ? 32'h1000 : 32'h0, '0);
      checkOutput("t6");
      pulseCount += int'(rise_o[12]) + int'(fall_o[12]);
    end
    check("t6 sw", sw_o, 32'h0);
    check("t6 flags", sw_changed_o, 32'h0);
    check("t6 pulses", W'(pulseCount), 32'h0);

    // Random phase: slowly varying switches, sparse clears, one mid-run reset
    resetDut();
    rawR = '0;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) rawR = rawR ^ ($urandom & $urandom);
      if (k == 200) resetDut();
      applyStimulus(rawR, ($urandom_range(0, 7) == 0) ? $urandom : 32'h0);
      checkOutput("rand");
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
